fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  IF stage plus IF/ID pipeline register of the MIPS core. Owns the PC, drives the
//  synchronous instruction SRAM and presents instr/pc/flags to the decode stage,
//  where main_dec and the branch comparator consume them.
//  Handles stalls, branch/jump redirects, delay-slot marking, exception entry and
//  instruction-address-error (AdEL) detection.
// PARAMETERS
//  RESET_PC   32'hBFC0_0000  PC loaded on reset
//  NOP_INSTR  32'h0000_0000  instruction injected into ID on flush/AdEL/bubble
// PORTS
//  clk              in   1   core clock, all state on posedge
//  rst              in   1   asynchronous active-high reset
//  stall_f          in   1   hold PC (hazard unit)
//  stall_d          in   1   hold IF/ID register
//  flush_d          in   1   replace IF/ID contents with bubble next edge
//  branch_d         in   1   instr in ID is branch/jump/jr (main_dec branch|jump|jumpr)
//  redirect_d       in   1   ID resolved a taken branch/jump this cycle
//  target_d         in   32  redirect target from ID
//  exc_redirect     in   1   one-cycle pulse from CP0 exception/eret logic
//  exc_pc           in   32  exception handler / EPC target, valid with exc_redirect
//  inst_sram_en     out  1   SRAM read enable
//  inst_sram_addr   out  32  SRAM byte address (= pc_f)
//  inst_sram_rdata  in   32  read data, valid one cycle after en
//  pc_f             out  32  current fetch PC
//  instr_d          out  32  instruction in ID
//  pc_d             out  32  PC of instr_d
//  pc_plus8_d       out  32  pc_d+8, link address for jal/jalr/bxxzal
//  valid_d          out  1   ID holds a real instruction (not bubble)
//  delayslot_d      out  1   instr_d sits in a branch delay slot
//  adel_d           out  1   instr_d fetch address misaligned (pc_d[1:0]!=0)
// BEHAVIOUR
//  Reset (async): pc_f=RESET_PC; IF/ID: pc_d=0, valid_d=0, delayslot_d=0, adel_d=0,
//   hold_valid=0, pending=0; instr_d=NOP_INSTR. inst_sram_en=0 while rst high.
//  SRAM: inst_sram_en = ~rst & ~stall_f & (pc_f[1:0]==0); addr = pc_f. Data for pc_f
//   issued in cycle N appears on rdata in N+1, i.e. aligned with pc_d.
//  Next PC priority (applied at edge when pc_f updates):
//   1 exc_redirect (ignores stall_f) -> exc_pc
//   2 pending & ~stall_f -> pend_pc, clear pending
//   3 redirect_d & ~stall_d -> target_d (the instr now in F is the delay slot, kept)
//   4 ~stall_f -> pc_f+4 (32-bit wrap, no overflow detection)
//   else hold pc_f.
//  Pending FSM RUN/PEND: exc_redirect while stall_f -> PEND, latch pend_pc=exc_pc.
//   Exception still redirects pc_f immediately; PEND only re-asserts the target when
//   stall_f drops, so a stall release cannot overwrite it with pc_f+4 of a stale fetch.
//   In PEND, redirect_d is ignored. PEND -> RUN on first ~stall_f edge.
//   A second exc_redirect in PEND overwrites pend_pc.
//  IF/ID register, priority: exc_redirect or flush_d -> bubble (valid_d=0,
//   delayslot_d=0, adel_d=0, instr NOP, hold cleared); else stall_d -> hold all;
//   else load pc_d=pc_f, valid_d=~pending, adel_d=(pc_f[1:0]!=0),
//   delayslot_d=branch_d & valid_d.
//  Hold buffer: rdata is not guaranteed stable while en=0. First stalled cycle with
//   valid_d & ~hold_valid captures rdata into hold_instr, sets hold_valid.
//   instr_d = ~valid_d|adel_d ? NOP_INSTR : hold_valid ? hold_instr : inst_sram_rdata.
//   hold_valid clears when ID advances or on flush.
//  pc_plus8_d = pc_d + 8 combinational.
//  Reset mid-operation: everything returns to reset values immediately; no pending
//   target survives.
// TESTING
//  1 Release rst, no stalls: pc_f 0xBFC00000,04,08; pc_d lags pc_f by 1 cycle;
//    instr_d = SRAM word at pc_d; valid_d=1 from 2nd cycle.
//  2 Taken beq at 0xBFC00010 (target 0xBFC00100): ID sequence 10, 14 (delayslot_d=1),
//    100; 0xBFC00018 never reaches ID.
//  3 stall_f=stall_d=1 for 3 cycles while SRAM rdata is scrambled after cycle 1:
//    instr_d and pc_d constant; after release the next pc_d is old pc_d+4.
//  4 exc_redirect pulse, exc_pc=0xBFC00380, stall_f=0: next-cycle pc_f=0xBFC00380,
//    valid_d=0 for one cycle, then instr from 0xBFC00380.
//  5 exc_redirect during 4-cycle stall_f: pending set; pc_f=0xBFC00380 on release;
//    concurrent redirect_d ignored.
//  6 Redirect to 0xBFC00102: adel_d=1, instr_d=0, inst_sram_en=0; assert rst mid-run:
//    pc_f=0xBFC00000, valid_d=0 immediately.

Source files
------------

// File: rtl/fetch_stage.sv
// IF stage and IF/ID register: owns the PC, reads the synchronous instruction SRAM, feeds decode.
// Latency: one cycle from pc_f to instr_d; stall_f/stall_d hold PC/IF/ID, a hold buffer keeps instr_d stable.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'hBFC0_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_f,
   input  logic        stall_d,
   input  logic        flush_d,
   input  logic        branch_d,
   input  logic        redirect_d,
   input  logic [31:0] target_d,
   input  logic        exc_redirect,
   input  logic [31:0] exc_pc,
   output logic        inst_sram_en,
   output logic [31:0] inst_sram_addr,
   input  logic [31:0] inst_sram_rdata,
   output logic [31:0] pc_f,
   output logic [31:0] instr_d,
   output logic [31:0] pc_d,
   output logic [31:0] pc_plus8_d,
   output logic        valid_d,
   output logic        delayslot_d,
   output logic        adel_d
);

   localparam logic [0:0] ST_RUN  = 1'b0;
   localparam logic [0:0] ST_PEND = 1'b1;

   typedef struct packed {
      logic [31:0] pc;
      logic        valid;
      logic        delayslot;
      logic        adel;
   } ifid_t;

   logic [31:0] pcf_q, pcf_d;
   logic [0:0]  state_q, state_d;
   logic [31:0] pend_pc_q, pend_pc_d;
   ifid_t       ifid_q, ifid_d;
   logic        hold_valid_q, hold_valid_d;
   logic [31:0] hold_instr_q, hold_instr_d;
   logic        pending;

   assign pending = (state_q == ST_PEND);

   // A pending exception target outranks ID redirects until the fetch stall drops.
   always_comb begin
      pcf_d = pcf_q;
      if (exc_redirect) begin
         pcf_d = exc_pc;
      end else if (pending && !stall_f) begin
         pcf_d = pend_pc_q;
      end else if (!pending && redirect_d && !stall_d) begin
         pcf_d = target_d;
      end else if (!stall_f) begin
         pcf_d = pcf_q + 32'd4;
      end
   end

   always_comb begin
      state_d   = state_q;
      pend_pc_d = pend_pc_q;
      case (state_q)
         ST_RUN: begin
            if (exc_redirect && stall_f) begin
               state_d   = ST_PEND;
               pend_pc_d = exc_pc;
            end
         end
         ST_PEND: begin
            if (exc_redirect && stall_f) begin
               pend_pc_d = exc_pc;
            end else if (!stall_f) begin
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_comb begin
      ifid_d       = ifid_q;
      hold_valid_d = hold_valid_q;
      hold_instr_d = hold_instr_q;
      if (exc_redirect || flush_d) begin
         ifid_d.valid     = 1'b0;
         ifid_d.delayslot = 1'b0;
         ifid_d.adel      = 1'b0;
         hold_valid_d     = 1'b0;
      end else if (stall_d) begin
         // SRAM output is only trustworthy on the first stalled cycle; keep a copy.
         if (ifid_q.valid && !hold_valid_q) begin
            hold_valid_d = 1'b1;
            hold_instr_d = inst_sram_rdata;
         end
      end else begin
         ifid_d.pc        = pcf_q;
         ifid_d.valid     = !pending;
         ifid_d.adel      = (pcf_q[1:0] != 2'b00);
         ifid_d.delayslot = branch_d && ifid_q.valid;
         hold_valid_d     = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pcf_q        <= RESET_PC;
         state_q      <= ST_RUN;
         pend_pc_q    <= 32'd0;
         ifid_q       <= '0;
         hold_valid_q <= 1'b0;
         hold_instr_q <= NOP_INSTR;
      end else begin
         pcf_q        <= pcf_d;
         state_q      <= state_d;
         pend_pc_q    <= pend_pc_d;
         ifid_q       <= ifid_d;
         hold_valid_q <= hold_valid_d;
         hold_instr_q <= hold_instr_d;
      end
   end

   assign inst_sram_en   = !rst && !stall_f && (pcf_q[1:0] == 2'b00);
   assign inst_sram_addr = pcf_q;
   assign pc_f           = pcf_q;

   assign instr_d     = (!ifid_q.valid || ifid_q.adel) ? NOP_INSTR :
                        hold_valid_q                   ? hold_instr_q : inst_sram_rdata;
   assign pc_d        = ifid_q.pc;
   assign pc_plus8_d  = ifid_q.pc + 32'd8;
   assign valid_d     = ifid_q.valid;
   assign delayslot_d = ifid_q.delayslot;
   assign adel_d      = ifid_q.adel;

endmodule
